// File: rtl/ddr2_port_arbiter_if.sv
`default_nettype none
// ddr2_port_arbiter_if: requester-side and controller-side signal bundle of the
// DDR2 port arbiter. The arbiter uses the slave modport; the environment uses master.
interface ddr2_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_PORTS-1:0]            port_req_i;
  logic [NUM_PORTS-1:0]            port_we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i;
  logic [NUM_PORTS-1:0]            port_ack_o;
  logic [NUM_PORTS-1:0]            port_rvalid_o;
  logic                            port_rerr_o;
  logic [DATA_WIDTH-1:0]           port_rdata_o;
  logic                            cntrl_idle_i;
  logic                            cntrl_calib_complete_i;
  logic                            cntrl_rd_request_o;
  logic                            cntrl_wr_request_o;
  logic [ADDR_WIDTH-1:0]           cntrl_address_o;
  logic [DATA_WIDTH-1:0]           cntrl_wr_data_o;
  logic [DATA_WIDTH-1:0]           cntrl_rd_data_i;
  logic                            cntrl_rd_data_valid_i;
  logic                            busy_o;

  modport slave (
    input  port_req_i, port_we_i, port_addr_i, port_wdata_i,
    input  cntrl_idle_i, cntrl_calib_complete_i, cntrl_rd_data_i, cntrl_rd_data_valid_i,
    output port_ack_o, port_rvalid_o, port_rerr_o, port_rdata_o,
    output cntrl_rd_request_o, cntrl_wr_request_o, cntrl_address_o, cntrl_wr_data_o,
    output busy_o
  );

  modport master (
    output port_req_i, port_we_i, port_addr_i, port_wdata_i,
    output cntrl_idle_i, cntrl_calib_complete_i, cntrl_rd_data_i, cntrl_rd_data_valid_i,
    input  port_ack_o, port_rvalid_o, port_rerr_o, port_rdata_o,
    input  cntrl_rd_request_o, cntrl_wr_request_o, cntrl_address_o, cntrl_wr_data_o,
    input  busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ddr2_port_arbiter.sv
`default_nettype none
// ddr2_port_arbiter: arbitrates NUM_PORTS byte requesters onto the single DDR2
// controller rd/wr request path and returns read data (or a timeout error) to the winner.
module ddr2_port_arbiter #(
  parameter int    NUM_PORTS  = 2,
  parameter int    ADDR_WIDTH = 27,
  parameter int    DATA_WIDTH = 8,
  parameter string ARB_MODE   = "ROUND_ROBIN",
  parameter int    RD_TIMEOUT = 1023
) (
  input wire                 clk_i,
  input wire                 rst_i,
  ddr2_port_arbiter_if.slave bus
);
  localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW         = $clog2(RD_TIMEOUT + 1);
  localparam bit FIXED_MODE = (ARB_MODE == "FIXED");
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_GAP     = 2'd2,
    S_WAIT_RD = 2'd3
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         grant_q;
  logic [PW-1:0]         ptr_q;
  logic                  we_q;
  logic [CW-1:0]         cnt_q;
  logic [NUM_PORTS-1:0]  ack_q;
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic                  rerr_q;
  logic                  rd_req_q;
  logic                  wr_req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [PW-1:0]         grant_d;
  logic [PW-1:0]         ptr_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  grant_en;
  int                    base;
  int                    off;
  int                    best;

  // Winner is the requester with the smallest distance from the base index
  // (0 for fixed priority, the round-robin pointer otherwise).
  always_comb begin
    grant_d = '0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    base    = FIXED_MODE ? 0 : int'(ptr_q);
    off     = 0;
    best    = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      off = i - base;
      if (off < 0) off = off + NUM_PORTS;
      if (bus.port_req_i[i] && (off < best)) begin
        best    = off;
        grant_d = PW'(i);
        we_d    = bus.port_we_i[i];
        addr_d  = bus.port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = bus.port_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d    = (grant_d == PW'(NUM_PORTS - 1)) ? '0 : grant_d + 1'b1;
    grant_en = (|bus.port_req_i) && bus.cntrl_idle_i && bus.cntrl_calib_complete_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      // Strobes are single-cycle pulses; address and data hold their last values.
      ack_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_req_q <= we_d;
            rd_req_q <= ~we_d;
            ack_q    <= ONE_HOT0 << grant_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= we_q ? S_GAP : S_WAIT_RD;
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        S_WAIT_RD: begin
          if (bus.cntrl_rd_data_valid_i) begin
            rdata_q  <= bus.cntrl_rd_data_i;
            rvalid_q <= ONE_HOT0 << grant_q;
            state_q  <= S_GAP;
          end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
            rdata_q  <= '0;
            rvalid_q <= ONE_HOT0 << grant_q;
            rerr_q   <= 1'b1;
            state_q  <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.port_ack_o         = ack_q;
  assign bus.port_rvalid_o      = rvalid_q;
  assign bus.port_rerr_o        = rerr_q;
  assign bus.port_rdata_o       = rdata_q;
  assign bus.cntrl_rd_request_o = rd_req_q;
  assign bus.cntrl_wr_request_o = wr_req_q;
  assign bus.cntrl_address_o    = addr_q;
  assign bus.cntrl_wr_data_o    = wdata_q;
  assign bus.busy_o             = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_ddr2_port_arbiter.sv
`default_nettype none
// tb_ddr2_port_arbiter: directed scoreboard bench for ddr2_port_arbiter (2-port RR with
// short read timeout, plus 3-port round-robin and fixed-priority instances).
module tb_ddr2_port_arbiter;
  localparam int AW = 27;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ddr2_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bA ();
  ddr2_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bR ();
  ddr2_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bF ();

  ddr2_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ARB_MODE("ROUND_ROBIN"), .RD_TIMEOUT(8))
    dut_a  (.clk_i(clk), .rst_i(rst), .bus(bA.slave));
  ddr2_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ARB_MODE("ROUND_ROBIN"), .RD_TIMEOUT(16))
    dut_rr (.clk_i(clk), .rst_i(rst), .bus(bR.slave));
  ddr2_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ARB_MODE("FIXED"), .RD_TIMEOUT(16))
    dut_fx (.clk_i(clk), .rst_i(rst), .bus(bF.slave));

  typedef struct {
    bit            we;
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } iss_t;
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    bit            err;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   rr_q[$];
  int   fx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_iss(input bit we, input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iss_t e;
    e.we = we; e.port = p; e.addr = a; e.data = d;
    iss_q.push_back(e);
  endtask

  task automatic exp_rsp(input int p, input logic [DW-1:0] d, input bit err);
    rsp_t e;
    e.port = p; e.data = d; e.err = err;
    rsp_q.push_back(e);
  endtask

  task automatic drive(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bA.port_req_i[p]             = 1'b1;
    bA.port_we_i[p]              = we;
    bA.port_addr_i[p*AW +: AW]   = a;
    bA.port_wdata_i[p*DW +: DW]  = d;
  endtask

  // Scoreboard for the 2-port instance: every issue and every read completion
  // must match the oldest expectation queued by the stimulus.
  iss_t mi;
  rsp_t mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (bA.cntrl_wr_request_o || bA.cntrl_rd_request_o) begin
        chk("issue_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          mi = iss_q.pop_front();
          chk("issue_wr", bA.cntrl_wr_request_o, mi.we);
          chk("issue_rd", bA.cntrl_rd_request_o, !mi.we);
          chk("issue_addr", bA.cntrl_address_o, mi.addr);
          if (mi.we) chk("issue_wdata", bA.cntrl_wr_data_o, mi.data);
          chk("issue_ack", bA.port_ack_o, 64'(1) << mi.port);
        end
      end else if (bA.port_ack_o != '0) begin
        chk("stray_ack", bA.port_ack_o, 0);
      end
      if (bA.port_rvalid_o != '0) begin
        chk("rsp_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          mr = rsp_q.pop_front();
          chk("rsp_port", bA.port_rvalid_o, 64'(1) << mr.port);
          chk("rsp_rdata", bA.port_rdata_o, mr.data);
          chk("rsp_rerr", bA.port_rerr_o, mr.err);
        end
      end
    end
  end

  int me_r;
  always @(negedge clk) begin
    if (!rst && bR.port_ack_o != '0) begin
      chk("rr_grant_expected", rr_q.size() > 0, 1);
      if (rr_q.size() > 0) begin
        me_r = rr_q.pop_front();
        chk("rr_grant", bR.port_ack_o, 64'(1) << me_r);
        chk("rr_addr", bR.cntrl_address_o, 64'h100 + 64'(me_r));
        chk("rr_wr_req", bR.cntrl_wr_request_o, 1);
      end
    end
  end

  int me_f;
  always @(negedge clk) begin
    if (!rst && bF.port_ack_o != '0) begin
      chk("fx_grant_expected", fx_q.size() > 0, 1);
      if (fx_q.size() > 0) begin
        me_f = fx_q.pop_front();
        chk("fx_grant", bF.port_ack_o, 64'(1) << me_f);
        chk("fx_addr", bF.cntrl_address_o, 64'h100 + 64'(me_f));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    bA.port_req_i = '0; bA.port_we_i = '0; bA.port_addr_i = '0; bA.port_wdata_i = '0;
    bA.cntrl_idle_i = 1'b1; bA.cntrl_calib_complete_i = 1'b1;
    bA.cntrl_rd_data_i = '0; bA.cntrl_rd_data_valid_i = 1'b0;
    bR.port_req_i = '0; bR.port_we_i = '0; bR.port_wdata_i = '0;
    bR.cntrl_idle_i = 1'b1; bR.cntrl_calib_complete_i = 1'b1;
    bR.cntrl_rd_data_i = '0; bR.cntrl_rd_data_valid_i = 1'b0;
    bF.port_req_i = '0; bF.port_we_i = '0; bF.port_wdata_i = '0;
    bF.cntrl_idle_i = 1'b1; bF.cntrl_calib_complete_i = 1'b1;
    bF.cntrl_rd_data_i = '0; bF.cntrl_rd_data_valid_i = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bR.port_addr_i[p*AW +: AW] = AW'(32'h100 + p);
      bF.port_addr_i[p*AW +: AW] = AW'(32'h100 + p);
    end
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", bA.busy_o, 0);
    chk("rst_ack", bA.port_ack_o, 0);
    chk("rst_rvalid", bA.port_rvalid_o, 0);
    chk("rst_rerr", bA.port_rerr_o, 0);
    chk("rst_rdata", bA.port_rdata_o, 0);
    chk("rst_cntrl_req", {bA.cntrl_wr_request_o, bA.cntrl_rd_request_o}, 0);
    chk("rst_cntrl_addr", bA.cntrl_address_o, 0);
    chk("rst_cntrl_wdata", bA.cntrl_wr_data_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // port 0 write
    drive(0, 1'b1, 27'h12, 8'hA5);
    exp_iss(1'b1, 0, 27'h12, 8'hA5);
    @(negedge clk);
    chk("t1_wr_req_cycle1", bA.cntrl_wr_request_o, 1);
    chk("t1_busy_cycle1", bA.busy_o, 1);
    bA.port_req_i[0] = 1'b0;
    @(negedge clk);
    chk("t1_wr_req_dropped", bA.cntrl_wr_request_o, 0);
    chk("t1_addr_held", bA.cntrl_address_o, 27'h12);
    @(negedge clk);
    chk("t1_busy_cycle3", bA.busy_o, 0);

    // port 1 read, data returned 5 cycles after the request
    drive(1, 1'b0, 27'h7FFFF, 8'h00);
    exp_iss(1'b0, 1, 27'h7FFFF, 8'h00);
    @(negedge clk);
    chk("t2_rd_req_cycle1", bA.cntrl_rd_request_o, 1);
    bA.port_req_i[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_waiting_busy", bA.busy_o, 1);
    bA.cntrl_rd_data_i = 8'h3C; bA.cntrl_rd_data_valid_i = 1'b1;
    exp_rsp(1, 8'h3C, 1'b0);
    @(negedge clk);
    bA.cntrl_rd_data_valid_i = 1'b0;
    chk("t2_rvalid_next_cycle", bA.port_rvalid_o, 2'b10);
    chk("t2_rdata", bA.port_rdata_o, 8'h3C);
    @(negedge clk);
    chk("t2_rvalid_pulse", bA.port_rvalid_o, 0);
    chk("t2_rdata_held", bA.port_rdata_o, 8'h3C);

    // 3-port arbitration, all ports writing continuously
    bR.port_we_i = 3'b111; bF.port_we_i = 3'b111;
    bR.port_req_i = 3'b111; bF.port_req_i = 3'b111;
    rr_q.push_back(0); rr_q.push_back(1); rr_q.push_back(2); rr_q.push_back(0);
    repeat (4) fx_q.push_back(0);
    n = 0;
    while ((rr_q.size() > 0 || fx_q.size() > 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    bR.port_req_i = '0; bF.port_req_i = '0;
    chk("t3_rr_all_grants", rr_q.size(), 0);
    chk("t3_fx_all_grants", fx_q.size(), 0);
    repeat (4) @(negedge clk);

    // read timeout: rvalid/rerr exactly 8 cycles into WAIT_RD
    drive(0, 1'b0, 27'h200, 8'h00);
    exp_iss(1'b0, 0, 27'h200, 8'h00);
    @(negedge clk);
    chk("t4_rd_req", bA.cntrl_rd_request_o, 1);
    bA.port_req_i[0] = 1'b0;
    exp_rsp(0, 8'h00, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bA.port_rvalid_o != '0) seen = 1'b1;
    end
    chk("t4_no_early_rvalid", seen, 0);
    @(negedge clk);
    chk("t4_timeout_rvalid", bA.port_rvalid_o, 2'b01);
    chk("t4_timeout_rerr", bA.port_rerr_o, 1);
    chk("t4_timeout_rdata", bA.port_rdata_o, 8'h00);
    @(negedge clk);

    // normal read after the timeout
    drive(0, 1'b0, 27'h201, 8'h00);
    exp_iss(1'b0, 0, 27'h201, 8'h00);
    @(negedge clk);
    chk("t4b_rd_req", bA.cntrl_rd_request_o, 1);
    bA.port_req_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    bA.cntrl_rd_data_i = 8'h5A; bA.cntrl_rd_data_valid_i = 1'b1;
    exp_rsp(0, 8'h5A, 1'b0);
    @(negedge clk);
    bA.cntrl_rd_data_valid_i = 1'b0;
    chk("t4b_rvalid", bA.port_rvalid_o, 2'b01);
    chk("t4b_rerr", bA.port_rerr_o, 0);
    chk("t4b_rdata", bA.port_rdata_o, 8'h5A);
    @(negedge clk);

    // valid arriving in the final WAIT_RD cycle beats the timeout
    drive(0, 1'b0, 27'h202, 8'h00);
    exp_iss(1'b0, 0, 27'h202, 8'h00);
    @(negedge clk);
    chk("t4c_rd_req", bA.cntrl_rd_request_o, 1);
    bA.port_req_i[0] = 1'b0;
    repeat (8) @(negedge clk);
    bA.cntrl_rd_data_i = 8'h77; bA.cntrl_rd_data_valid_i = 1'b1;
    exp_rsp(0, 8'h77, 1'b0);
    @(negedge clk);
    bA.cntrl_rd_data_valid_i = 1'b0;
    chk("t4c_valid_wins_rvalid", bA.port_rvalid_o, 2'b01);
    chk("t4c_valid_wins_rerr", bA.port_rerr_o, 0);
    chk("t4c_valid_wins_rdata", bA.port_rdata_o, 8'h77);
    @(negedge clk);

    // calibration gating; pointer is at 1 so port 1 wins first
    bA.cntrl_calib_complete_i = 1'b0;
    drive(0, 1'b1, 27'h300, 8'h11);
    drive(1, 1'b1, 27'h301, 8'h22);
    repeat (5) @(negedge clk);
    chk("t5_no_grant_uncal_busy", bA.busy_o, 0);
    chk("t5_no_grant_uncal_ack", bA.port_ack_o, 0);
    exp_iss(1'b1, 1, 27'h301, 8'h22);
    exp_iss(1'b1, 0, 27'h300, 8'h11);
    bA.cntrl_calib_complete_i = 1'b1;
    @(negedge clk);
    chk("t5_grant_after_calib", bA.cntrl_wr_request_o, 1);
    chk("t5_grant_port1", bA.port_ack_o, 2'b10);
    bA.port_req_i[1] = 1'b0;
    n = 0;
    while (!bA.port_ack_o[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_port0_served", bA.port_ack_o[0], 1);
    bA.port_req_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    bA.cntrl_rd_data_i = 8'hFF; bA.cntrl_rd_data_valid_i = 1'b1;
    @(negedge clk);
    bA.cntrl_rd_data_valid_i = 1'b0;
    @(negedge clk);
    chk("t5_stray_valid_rdata", bA.port_rdata_o, 8'h77);
    chk("t5_stray_valid_rvalid", bA.port_rvalid_o, 0);

    // reset in the middle of WAIT_RD
    drive(1, 1'b0, 27'h400, 8'h00);
    exp_iss(1'b0, 1, 27'h400, 8'h00);
    @(negedge clk);
    chk("t6_rd_req", bA.cntrl_rd_request_o, 1);
    bA.port_req_i[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_in_wait_rd", bA.busy_o, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_busy", bA.busy_o, 0);
    chk("t6_async_rdata", bA.port_rdata_o, 0);
    chk("t6_async_addr", bA.cntrl_address_o, 0);
    chk("t6_async_strobes", {bA.port_ack_o, bA.port_rvalid_o, bA.port_rerr_o,
                             bA.cntrl_wr_request_o, bA.cntrl_rd_request_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bA.cntrl_rd_data_i = 8'h99; bA.cntrl_rd_data_valid_i = 1'b1;
    @(negedge clk);
    bA.cntrl_rd_data_valid_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bA.port_rvalid_o != '0) seen = 1'b1;
    end
    chk("t6_no_rvalid_after_reset", seen, 0);
    chk("t6_rdata_after_reset", bA.port_rdata_o, 0);

    chk("end_issue_queue_empty", iss_q.size(), 0);
    chk("end_rsp_queue_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
